alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
Shares the single execution ALU between two requesters, req0 (integer pipeline) and req1 (debug/microcode port), using round-robin arbitration. Latches the winning request's 4-bit ALU control code and operands, then holds them stable on the ALU inputs for the op's latency: 1 cycle for logic/add/sub, MUL_CYCLES for mul, DIV_CYCLES for div. Registers the result and returns it with a requester ID over a valid/ready response channel. It rejects illegal control codes, and divides by zero, without occupying the ALU.

Parameters:
WIDTH, 16, operand/result width
MUL_CYCLES, 3, cycles operands are held for mul (control 4'b0110), min 1
DIV_CYCLES, 8, cycles operands are held for div (control 4'b0111), min 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_control  in  4  ALU control code
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req1_valid, req1_ready, req1_control, req1_a, req1_b  same as req0, for requester 1
alu_control  out  4  to ALU; registered
alu_a  out  WIDTH  to ALU; registered
alu_b  out  WIDTH  to ALU; registered
alu_result  in  WIDTH  combinational ALU result
resp_valid  out  1  response available
resp_ready  in  1  consumer takes response
resp_id  out  1  requester that issued the op
resp_result  out  WIDTH  registered result
resp_error  out  1  illegal code or div-by-zero
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, takes effect at the next edge): state=IDLE, prio=0, counter=0. All registered outputs are 0: alu_control, alu_a, alu_b, resp_valid, resp_id, resp_result, resp_error. An in-flight op is discarded with no response.
- States: IDLE, EXEC, DONE.
- IDLE arbitration:
  - Only one valid: that requester wins.
  - Both valid: requester `prio` wins.
  - reqN_ready = 1 only for the winner, combinationally, and only in IDLE. Never both ready in the same cycle.
- Accept (handshake at the edge where valid & ready):
  - Latch control, a, b into the alu_* registers and the ID into resp_id.
  - prio <= ~winner. prio changes only on accept.
- Op classes by the control value:
  - 0000 not, 0001 and, 0010 or, 0011 xor, 0100 add, 0101 sub: legal, L=1.
  - 0110 mul: L=MUL_CYCLES.
  - 0111 div: L=DIV_CYCLES.
  - 1xxx: illegal.
- IDLE → EXEC on accept of a legal op with no div-by-zero; counter <= L-1.
- IDLE → DONE directly on accept of an illegal op or a div with b==0:
  - resp_result <= all-ones, resp_error <= 1.
  - The alu_* registers are still loaded, but the result is ignored.
- EXEC:
  - counter != 0: counter decrements.
  - counter == 0: resp_result <= alu_result, resp_error <= 0, resp_valid <= 1, go to DONE.
  - The alu_* registers stay constant for all L cycles.
- Latency: accept at edge E gives resp_valid high from cycle E+L+1. A 1-cycle op accepted at edge E has EXEC during cycle E+1 and resp_valid in cycle E+2.
- DONE:
  - resp_valid = 1; resp_id, resp_result and resp_error are held stable until resp_valid & resp_ready.
  - On the handshake edge: resp_valid <= 0, go to IDLE.
  - No new accept can occur in the handshake cycle; the earliest next accept is the cycle after. Max throughput is one op per L+2 cycles.
- A requester's valid dropping before it is accepted is legal and leaves no state change. Requesters are expected to hold their fields while valid & !ready.
- busy = (state != IDLE), combinational.
- Simultaneous reset and handshake: reset wins.

Test Plan:
- Single add, req0, a=5, b=7, control 0100, resp_ready=1: req0_ready in the accept cycle; alu_* = 0100/5/7; two cycles later resp_valid=1, id=0, result=12, error=0.
- mul, req1, MUL_CYCLES=3, a=6, b=7, control 0110: alu_control=0110 held stable for exactly 3 cycles; resp_valid appears 4 cycles after accept with id=1, result=42.
- Both valid continuously with add ops after reset: grants go 0,1,0,1; req0_ready and req1_ready are never high together; each response's id matches its grant.
- Control 1010 from req0, and separately div with b=0: busy goes to DONE the next cycle with no EXEC; resp_error=1, result=16'hFFFF.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises; outputs stay stable, both readys stay 0; the next accept occurs the cycle after resp_ready=1.
- Assert reset for 1 cycle mid-div (counter=4): the next cycle shows IDLE, resp_valid=0, all alu_* = 0, prio=0; a following req0/req1 tie grants req0.

Source files
------------

// File: rtl/alu_issue_arbiter_if.sv
// Bundle of the two requester ports, the ALU drive/return path and the response channel.
// The arbiter takes the slave view; whatever drives requests and consumes responses takes the master view.
interface alu_issue_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_control;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_control;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_error;
  logic             busy;

  modport slave (
    input  req0_valid, req0_control, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_control, req1_a, req1_b,
    output req1_ready,
    output alu_control, alu_a, alu_b,
    input  alu_result,
    output resp_valid, resp_id, resp_result, resp_error,
    input  resp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_control, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_control, req1_a, req1_b,
    input  req1_ready,
    input  alu_control, alu_a, alu_b,
    output alu_result,
    input  resp_valid, resp_id, resp_result, resp_error,
    output resp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of ops from two requesters onto one shared ALU; operands are held for the
// op latency and the result comes back on a valid/ready response with the requester id.
module alu_issue_arbiter #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  alu_issue_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // Counter only ever holds L-1, so log2(max L) bits are enough.
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_CYCLES - 1);

  state_t             state_r;
  state_t             state_n;
  logic               prio_r;
  logic [CNT_W-1:0]   counter_r;
  logic [3:0]         alu_control_r;
  logic [WIDTH-1:0]   alu_a_r;
  logic [WIDTH-1:0]   alu_b_r;
  logic               resp_valid_r;
  logic               resp_id_r;
  logic [WIDTH-1:0]   resp_result_r;
  logic               resp_error_r;

  logic               winner_s;
  logic               grant_s;
  logic [3:0]         sel_control_s;
  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;
  logic [CNT_W-1:0]   lat_m1_s;
  logic               reject_s;

  // Pick the winner: a lone valid requester wins, a tie goes to prio_r.
  always_comb begin
    winner_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      winner_s = prio_r;
    end else if (bus.req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  assign grant_s        = (state_r == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = grant_s && !winner_s;
  assign bus.req1_ready = grant_s && winner_s;

  assign sel_control_s = winner_s ? bus.req1_control : bus.req0_control;
  assign sel_a_s       = winner_s ? bus.req1_a       : bus.req0_a;
  assign sel_b_s       = winner_s ? bus.req1_b       : bus.req0_b;

  // Decode the winning op into its hold latency and whether it bypasses the ALU.
  always_comb begin
    lat_m1_s = {CNT_W{1'b0}};
    reject_s = 1'b0;
    case (sel_control_s)
      4'b0000, 4'b0001, 4'b0010,
      4'b0011, 4'b0100, 4'b0101: begin
        lat_m1_s = {CNT_W{1'b0}};
        reject_s = 1'b0;
      end
      4'b0110: begin
        lat_m1_s = MUL_M1;
        reject_s = 1'b0;
      end
      4'b0111: begin
        lat_m1_s = DIV_M1;
        reject_s = (sel_b_s == {WIDTH{1'b0}});
      end
      default: begin
        lat_m1_s = {CNT_W{1'b0}};
        reject_s = 1'b1;
      end
    endcase
  end

  // Next-state logic of the issue FSM.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_n = reject_s ? DONE : EXEC;
        end else begin
          state_n = IDLE;
        end
      end
      EXEC: begin
        if (counter_r == {CNT_W{1'b0}}) begin
          state_n = DONE;
        end else begin
          state_n = EXEC;
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Operand latch, latency counter, round-robin pointer and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_r        <= 1'b0;
      counter_r     <= {CNT_W{1'b0}};
      alu_control_r <= 4'b0000;
      alu_a_r       <= {WIDTH{1'b0}};
      alu_b_r       <= {WIDTH{1'b0}};
      resp_valid_r  <= 1'b0;
      resp_id_r     <= 1'b0;
      resp_result_r <= {WIDTH{1'b0}};
      resp_error_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            alu_control_r <= sel_control_s;
            alu_a_r       <= sel_a_s;
            alu_b_r       <= sel_b_s;
            resp_id_r     <= winner_s;
            prio_r        <= ~winner_s;
            counter_r     <= lat_m1_s;
            // Rejected ops still load the ALU inputs but answer straight away.
            if (reject_s) begin
              resp_result_r <= {WIDTH{1'b1}};
              resp_error_r  <= 1'b1;
              resp_valid_r  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (counter_r != {CNT_W{1'b0}}) begin
            counter_r <= counter_r - CNT_W'(1);
          end else begin
            resp_result_r <= bus.alu_result;
            resp_error_r  <= 1'b0;
            resp_valid_r  <= 1'b1;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_control = alu_control_r;
  assign bus.alu_a       = alu_a_r;
  assign bus.alu_b       = alu_b_r;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_id     = resp_id_r;
  assign bus.resp_result = resp_result_r;
  assign bus.resp_error  = resp_error_r;
  assign bus.busy        = (state_r != IDLE);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a behavioural ALU on the alu_* bus.
module tb_alu_issue_arbiter;
  localparam int WIDTH = 16;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  alu_issue_arbiter_if #(.WIDTH(WIDTH)) ifc ();

  alu_issue_arbiter #(.WIDTH(WIDTH), .MUL_CYCLES(3), .DIV_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU driven by the arbiter's registered operands.
  always_comb begin
    ifc.alu_result = 16'h0000;
    case (ifc.alu_control)
      4'b0000: ifc.alu_result = ~ifc.alu_a;
      4'b0001: ifc.alu_result = ifc.alu_a & ifc.alu_b;
      4'b0010: ifc.alu_result = ifc.alu_a | ifc.alu_b;
      4'b0011: ifc.alu_result = ifc.alu_a ^ ifc.alu_b;
      4'b0100: ifc.alu_result = ifc.alu_a + ifc.alu_b;
      4'b0101: ifc.alu_result = ifc.alu_a - ifc.alu_b;
      4'b0110: ifc.alu_result = ifc.alu_a * ifc.alu_b;
      4'b0111: ifc.alu_result = (ifc.alu_b != 16'h0000) ? (ifc.alu_a / ifc.alu_b) : 16'hFFFF;
      default: ifc.alu_result = 16'h0000;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    ifc.req0_valid = 1'b0; ifc.req0_control = 4'b0000; ifc.req0_a = 16'h0000; ifc.req0_b = 16'h0000;
    ifc.req1_valid = 1'b0; ifc.req1_control = 4'b0000; ifc.req1_a = 16'h0000; ifc.req1_b = 16'h0000;
    ifc.resp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", ifc.busy, 0);
    chk("rst_valid", ifc.resp_valid, 0);
    chk("rst_ctrl", ifc.alu_control, 0);
    chk("rst_a", ifc.alu_a, 0);
    chk("rst_result", ifc.resp_result, 0);
    chk("rst_ready0", ifc.req0_ready, 0);

    // Single add from req0.
    ifc.req0_valid = 1'b1; ifc.req0_control = 4'b0100; ifc.req0_a = 16'd5; ifc.req0_b = 16'd7;
    ifc.resp_ready = 1'b1;
    #1;
    chk("add_ready0", ifc.req0_ready, 1);
    chk("add_ready1", ifc.req1_ready, 0);
    tick();
    ifc.req0_valid = 1'b0;
    #1;
    chk("add_ctrl", ifc.alu_control, 4'b0100);
    chk("add_a", ifc.alu_a, 5);
    chk("add_b", ifc.alu_b, 7);
    chk("add_busy", ifc.busy, 1);
    chk("add_early_valid", ifc.resp_valid, 0);
    tick();
    chk("add_valid", ifc.resp_valid, 1);
    chk("add_id", ifc.resp_id, 0);
    chk("add_result", ifc.resp_result, 12);
    chk("add_error", ifc.resp_error, 0);
    tick();
    chk("add_drain_valid", ifc.resp_valid, 0);
    chk("add_drain_busy", ifc.busy, 0);

    // Mul from req1, then 5 cycles of backpressure with req0 waiting.
    ifc.resp_ready = 1'b0;
    ifc.req1_valid = 1'b1; ifc.req1_control = 4'b0110; ifc.req1_a = 16'd6; ifc.req1_b = 16'd7;
    #1;
    chk("mul_ready1", ifc.req1_ready, 1);
    chk("mul_ready0", ifc.req0_ready, 0);
    tick();
    ifc.req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mul_hold_ctrl", ifc.alu_control, 4'b0110);
      chk("mul_hold_a", ifc.alu_a, 6);
      chk("mul_not_valid", ifc.resp_valid, 0);
      tick();
    end
    ifc.req0_valid = 1'b1; ifc.req0_control = 4'b0100; ifc.req0_a = 16'd1; ifc.req0_b = 16'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", ifc.resp_valid, 1);
      chk("bp_id", ifc.resp_id, 1);
      chk("bp_result", ifc.resp_result, 42);
      chk("bp_ready0", ifc.req0_ready, 0);
      chk("bp_ready1", ifc.req1_ready, 0);
      tick();
    end
    ifc.resp_ready = 1'b1;
    #1;
    chk("bp_hs_ready0", ifc.req0_ready, 0);
    tick();
    chk("bp_after_valid", ifc.resp_valid, 0);
    chk("bp_after_ready0", ifc.req0_ready, 1);
    tick();
    ifc.req0_valid = 1'b0;
    tick();
    chk("add2_valid", ifc.resp_valid, 1);
    chk("add2_result", ifc.resp_result, 3);
    chk("add2_id", ifc.resp_id, 0);
    tick();
    chk("add2_drain", ifc.resp_valid, 0);

    // Illegal control code from req0.
    ifc.req0_valid = 1'b1; ifc.req0_control = 4'b1010; ifc.req0_a = 16'd3; ifc.req0_b = 16'd4;
    #1;
    chk("ill_ready0", ifc.req0_ready, 1);
    tick();
    ifc.req0_valid = 1'b0;
    #1;
    chk("ill_busy", ifc.busy, 1);
    chk("ill_valid", ifc.resp_valid, 1);
    chk("ill_error", ifc.resp_error, 1);
    chk("ill_result", ifc.resp_result, 16'hFFFF);
    chk("ill_id", ifc.resp_id, 0);
    chk("ill_ctrl", ifc.alu_control, 4'b1010);
    tick();
    chk("ill_drain", ifc.resp_valid, 0);
    chk("ill_idle", ifc.busy, 0);

    // Divide by zero from req1.
    ifc.req1_valid = 1'b1; ifc.req1_control = 4'b0111; ifc.req1_a = 16'd9; ifc.req1_b = 16'd0;
    #1;
    chk("dz_ready1", ifc.req1_ready, 1);
    tick();
    ifc.req1_valid = 1'b0;
    #1;
    chk("dz_valid", ifc.resp_valid, 1);
    chk("dz_error", ifc.resp_error, 1);
    chk("dz_result", ifc.resp_result, 16'hFFFF);
    chk("dz_id", ifc.resp_id, 1);
    tick();
    chk("dz_drain", ifc.resp_valid, 0);

    // Reset in the middle of a div with the counter at 4.
    ifc.req1_valid = 1'b1; ifc.req1_control = 4'b0111; ifc.req1_a = 16'd100; ifc.req1_b = 16'd7;
    #1;
    chk("div_ready1", ifc.req1_ready, 1);
    tick();
    ifc.req1_valid = 1'b0;
    tick(); tick(); tick();
    chk("div_busy", ifc.busy, 1);
    chk("div_ctrl", ifc.alu_control, 4'b0111);
    chk("div_not_valid", ifc.resp_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", ifc.busy, 0);
    chk("mrst_valid", ifc.resp_valid, 0);
    chk("mrst_ctrl", ifc.alu_control, 0);
    chk("mrst_a", ifc.alu_a, 0);
    chk("mrst_b", ifc.alu_b, 0);
    chk("mrst_id", ifc.resp_id, 0);
    chk("mrst_result", ifc.resp_result, 0);

    // Continuous tie: grants must alternate 0,1,0,1 starting from req0.
    ifc.req0_valid = 1'b1; ifc.req0_control = 4'b0100; ifc.req0_a = 16'd10; ifc.req0_b = 16'd1;
    ifc.req1_valid = 1'b1; ifc.req1_control = 4'b0100; ifc.req1_a = 16'd20; ifc.req1_b = 16'd2;
    ifc.resp_ready = 1'b1;
    #1;
    chk("tie_ready0", ifc.req0_ready, 1);
    chk("tie_ready1", ifc.req1_ready, 0);
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(ifc.req0_ready || ifc.req1_ready) && n < 10) begin
        chk("rr_mutex", ifc.req0_ready & ifc.req1_ready, 0);
        tick();
        n++;
      end
      chk("rr_grant_wait", (n < 10), 1);
      chk("rr_mutex", ifc.req0_ready & ifc.req1_ready, 0);
      chk("rr_grant", ifc.req1_ready, g % 2);
      tick();
      n = 0;
      while (!ifc.resp_valid && n < 20) begin
        chk("rr_mutex", ifc.req0_ready & ifc.req1_ready, 0);
        tick();
        n++;
      end
      chk("rr_resp_wait", (n < 20), 1);
      chk("rr_id", ifc.resp_id, g % 2);
      chk("rr_result", ifc.resp_result, (g % 2 == 1) ? 22 : 11);
      tick();
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
